// File: rtl/cia_bus_master_if.sv
// Command/response stream and CIA core bus signals for cia_bus_master.
// The master modport is the sequencer side; slave is the command source / core side.
interface cia_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       phi2;
    logic       res_n;
    logic       cs_n;
    logic       r_w_n;
    logic [3:0] addr;
    logic [7:0] data_o;
    logic [7:0] data_i;
    logic [1:0] state_dbg;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, data_i,
        output cmd_ready, rsp_valid, rsp_data, busy, phi2, res_n,
               cs_n, r_w_n, addr, data_o, state_dbg
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, data_i,
        input  cmd_ready, rsp_valid, rsp_data, busy, phi2, res_n,
               cs_n, r_w_n, addr, data_o, state_dbg
    );
endinterface

// File: rtl/cia_bus_master.sv
// Drives the CIA core bus from a queued command stream: generates PHI2, sequences
// core reset, and issues one PHI2-aligned register access per queued command.
module cia_bus_master #(
    parameter int HALF       = 8,
    parameter int DEPTH      = 4,
    parameter int RES_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    cia_bus_master_if.master  bus
);
    localparam int HW = $clog2(HALF);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RES_CYCLES + 1);

    typedef enum logic {SEQ_RESET, SEQ_RUN} seq_e;
    typedef enum logic {ACC_IDLE, ACC_ACCESS} acc_e;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;

    logic [HW-1:0] hc_q, hc_d;
    logic          phi2_q, phi2_d;
    seq_e          seq_q, seq_d;
    logic [CW-1:0] res_cnt_q, res_cnt_d;
    acc_e          acc_q, acc_d;
    logic          acc_rd_q, acc_rd_d;
    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          cs_n_q, cs_n_d;
    logic          r_w_n_q, r_w_n_d;
    logic [3:0]    addr_q, addr_d;
    logic [7:0]    data_o_q, data_o_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;

    logic hc_last, lp, empty, full, push, pop, res_done, run_now;
    cmd_t head;

    // Handshake: a command transfers on any clk edge where cmd_valid & cmd_ready;
    // cmd_ready depends only on FIFO occupancy, never on cmd_valid, and a full
    // FIFO refuses even when the head is popped in the same cycle.
    always_comb begin
        hc_last  = (hc_q == HW'(HALF - 1));
        lp       = phi2_q & hc_last;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push     = bus.cmd_valid & ~full;
        head     = mem_q[rd_ptr_q[AW-1:0]];
        res_done = (res_cnt_q == CW'(RES_CYCLES - 1));
        // The LP that releases the core may already launch a queued command.
        run_now  = (seq_q == SEQ_RUN) | (lp & res_done);
        pop      = lp & run_now & ~empty;

        hc_d   = hc_last ? '0 : hc_q + HW'(1);
        phi2_d = hc_last ? ~phi2_q : phi2_q;

        seq_d     = seq_q;
        res_cnt_d = res_cnt_q;
        if (seq_q == SEQ_RESET && lp) begin
            res_cnt_d = res_cnt_q + CW'(1);
            if (res_done) begin
                seq_d = SEQ_RUN;
            end
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {bus.cmd_we, bus.cmd_addr, bus.cmd_data};
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end

        acc_d       = acc_q;
        acc_rd_d    = acc_rd_q;
        cs_n_d      = cs_n_q;
        r_w_n_d     = r_w_n_q;
        addr_d      = addr_q;
        data_o_d    = data_o_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        if (lp) begin
            if (acc_q == ACC_ACCESS && acc_rd_q) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.data_i;
            end
            if (pop) begin
                acc_d    = ACC_ACCESS;
                acc_rd_d = ~head.we;
                cs_n_d   = 1'b0;
                r_w_n_d  = ~head.we;
                addr_d   = head.addr;
                data_o_d = head.we ? head.data : 8'h00;
            end else begin
                acc_d    = ACC_IDLE;
                acc_rd_d = 1'b0;
                cs_n_d   = 1'b1;
                r_w_n_d  = 1'b1;
                addr_d   = 4'h0;
                data_o_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q        <= '0;
            phi2_q      <= 1'b0;
            seq_q       <= SEQ_RESET;
            res_cnt_q   <= '0;
            acc_q       <= ACC_IDLE;
            acc_rd_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cs_n_q      <= 1'b1;
            r_w_n_q     <= 1'b1;
            addr_q      <= 4'h0;
            data_o_q    <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            hc_q        <= hc_d;
            phi2_q      <= phi2_d;
            seq_q       <= seq_d;
            res_cnt_q   <= res_cnt_d;
            acc_q       <= acc_d;
            acc_rd_q    <= acc_rd_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cs_n_q      <= cs_n_d;
            r_w_n_q     <= r_w_n_d;
            addr_q      <= addr_d;
            data_o_q    <= data_o_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready = ~full;
    assign bus.busy      = ~empty | (acc_q == ACC_ACCESS);
    assign bus.phi2      = phi2_q;
    assign bus.res_n     = (seq_q == SEQ_RUN);
    assign bus.cs_n      = cs_n_q;
    assign bus.r_w_n     = r_w_n_q;
    assign bus.addr      = addr_q;
    assign bus.data_o    = data_o_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.state_dbg = {seq_q == SEQ_RUN, acc_q == ACC_ACCESS};
endmodule
